note_tone_gen: RTL and testbench

Square-wave tone generator that is the consumer side of the keypad note interface. It takes the 4-bit note code and 4-bit octave produced by the keypad front end and drives a 1-bit audio output (buzzer/PWM pin) at the corresponding equal-tempered pitch. All pitch changes are glitch-free: they take effect only at half-period boundaries. The block sits between the keypad/sequencer note bus and the board audio pin, running on the 100 MHz system clock.

---
 rtl/note_tone_pkg.sv | 21 ++
 rtl/note_period_lut.sv | 30 +++
 rtl/note_tone_gen.sv | 80 ++++++++
 tb/tb_note_tone_gen.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/note_tone_pkg.sv
// Shared constants, note codes and the octave-9 half-period table for the tone generator.
package note_tone_pkg;

  localparam int NOTE_W  = 4;
  localparam int OCT_W   = 4;
  localparam int CNT_W   = 22;
  localparam int MAX_OCT = 9;

  typedef enum logic [NOTE_W-1:0] {
    REST = 4'd0, C = 4'd1, CS, D, DS, E, F, FS, G, GS, A, AS, B
  } note_t;

  typedef enum logic {IDLE = 1'b0, PLAY = 1'b1} state_t;

  // Octave-9 half-periods in 100 MHz clocks, indexed by note code minus one.
  localparam logic [CNT_W-1:0] BASE [12] = '{
    22'd5972, 22'd5637, 22'd5321, 22'd5022, 22'd4740, 22'd4474,
    22'd4223, 22'd3986, 22'd3762, 22'd3551, 22'd3352, 22'd3164
  };

endpackage

// File: rtl/note_period_lut.sv
// Stage 2: maps registered note/octave to a registered half-period target (0 = rest).
module note_period_lut
  import note_tone_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [NOTE_W-1:0] note_q,
  input  logic [OCT_W-1:0]  oct_q,
  output logic [CNT_W-1:0]  target
);

  logic [CNT_W-1:0]  target_d;
  logic [NOTE_W-1:0] idx;
  logic [OCT_W-1:0]  sh;

  always_comb begin
    target_d = '0;
    idx      = note_q - 4'd1;
    sh       = OCT_W'(MAX_OCT) - oct_q;
    // Codes past B and octaves past MAX_OCT fall through to rest.
    if ((note_q != REST) && (note_q <= B) && (oct_q <= OCT_W'(MAX_OCT)))
      target_d = BASE[idx] << sh;
  end

  always_ff @(posedge clk) begin
    if (rst) target <= '0;
    else     target <= target_d;
  end

endmodule

// File: rtl/note_tone_gen.sv
// Square-wave tone generator; pitch changes only take effect at half-period boundaries.
module note_tone_gen
  import note_tone_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [NOTE_W-1:0] note,
  input  logic [OCT_W-1:0]  octave,
  output logic              audio,
  output logic              active,
  output logic [CNT_W-1:0]  half_period
);

  logic [NOTE_W-1:0] note_q;
  logic [OCT_W-1:0]  oct_q;
  logic [CNT_W-1:0]  target;
  logic [CNT_W-1:0]  cnt;
  state_t            state;

  always_ff @(posedge clk) begin
    if (rst) begin
      note_q <= '0;
      oct_q  <= '0;
    end else begin
      note_q <= note;
      oct_q  <= octave;
    end
  end

  note_period_lut u_lut (
    .clk    (clk),
    .rst    (rst),
    .note_q (note_q),
    .oct_q  (oct_q),
    .target (target)
  );

  assign half_period = target;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      audio  <= 1'b0;
      active <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          audio  <= 1'b0;
          active <= 1'b0;
          if (target != '0) begin
            state  <= PLAY;
            audio  <= 1'b1;
            active <= 1'b1;
            cnt    <= target - CNT_W'(1);
          end
        end
        PLAY: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else if (target == '0) begin
            state  <= IDLE;
            audio  <= 1'b0;
            active <= 1'b0;
          end else begin
            // Target is re-sampled here, so each level uses the value seen at its start.
            audio <= ~audio;
            cnt   <= target - CNT_W'(1);
          end
        end
        default: begin
          state  <= IDLE;
          audio  <= 1'b0;
          active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_note_tone_gen.sv
// Directed self-checking bench for note_tone_gen using octave-9 tones to keep runs short.
module tb_note_tone_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  note;
  logic [3:0]  octave;
  logic        audio;
  logic        active;
  logic [21:0] half_period;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  note_tone_gen dut (
    .clk         (clk),
    .rst         (rst),
    .note        (note),
    .octave      (octave),
    .audio       (audio),
    .active      (active),
    .half_period (half_period)
  );

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Counts samples while audio holds lvl; returns the level length in clocks.
  task automatic measure_level(input logic lvl, output int len);
    len = 0;
    while (audio === lvl && len < 20000) begin
      len++;
      tick(1);
    end
  endtask

  task automatic wait_rise(input string name);
    int n = 0;
    while (audio !== 1'b1 && n < 20000) begin
      n++;
      tick(1);
    end
    checks++;
    if (audio !== 1'b1) begin
      errors++;
      $display("FAIL %s: audio never rose, got %b want 1", name, audio);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; note = 4'd0; octave = 4'd0;
    tick(1);
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (audio !== 1'b0 || active !== 1'b0 || half_period !== 22'd0) begin
      errors++;
      $display("FAIL reset: audio=%b active=%b hp=%0d want 0 0 0", audio, active, half_period);
    end
  endtask

  task automatic test_lut_values();
    logic [3:0]  nv [8] = '{4'd10, 4'd1, 4'd12, 4'd1, 4'd13, 4'd10, 4'd0, 4'd14};
    logic [3:0]  ov [8] = '{4'd4, 4'd0, 4'd9, 4'd4, 4'd4, 4'd10, 4'd5, 4'd9};
    logic [21:0] ev [8] = '{22'd113632, 22'd3057664, 22'd3164, 22'd191104,
                            22'd0, 22'd0, 22'd0, 22'd0};
    for (int i = 0; i < 8; i++) begin
      note = nv[i]; octave = ov[i];
      tick(2);
      checks++;
      if (half_period !== ev[i]) begin
        errors++;
        $display("FAIL lut[%0d] n=%0d o=%0d: hp=%0d want %0d", i, nv[i], ov[i], half_period, ev[i]);
      end
    end
    do_reset();
  endtask

  task automatic test_start_and_period();
    int len;
    note = 4'd10; octave = 4'd9;
    tick(2);
    checks++;
    if (audio !== 1'b0 || half_period !== 22'd3551) begin
      errors++;
      $display("FAIL start_c2: audio=%b hp=%0d want 0 3551", audio, half_period);
    end
    tick(1);
    checks++;
    if (audio !== 1'b1 || active !== 1'b1) begin
      errors++;
      $display("FAIL start_c3: audio=%b active=%b want 1 1", audio, active);
    end
    for (int p = 0; p < 2; p++) begin
      int hi, lo;
      measure_level(1'b1, hi);
      measure_level(1'b0, lo);
      checks++;
      if (hi + lo !== 7102 || hi !== 3551) begin
        errors++;
        $display("FAIL period[%0d]: high=%0d low=%0d want 3551 3551", p, hi, lo);
      end
    end
    note = 4'd12;
    measure_level(1'b1, len);
    measure_level(1'b0, len);
    measure_level(1'b1, len);
    checks++;
    if (len !== 3164 || active !== 1'b1) begin
      errors++;
      $display("FAIL b9_high: len=%0d active=%b want 3164 1", len, active);
    end
    do_reset();
  endtask

  task automatic test_mid_change();
    int hi, lo, hi2;
    note = 4'd10; octave = 4'd9;
    wait_rise("mid_rise");
    tick(1000);
    note = 4'd1;
    measure_level(1'b1, hi);
    hi = hi + 1000;
    measure_level(1'b0, lo);
    measure_level(1'b1, hi2);
    checks++;
    if (hi !== 3551 || lo !== 5972 || hi2 !== 5972) begin
      errors++;
      $display("FAIL mid_change: hi=%0d lo=%0d hi2=%0d want 3551 5972 5972", hi, lo, hi2);
    end
    do_reset();
  endtask

  task automatic test_rest_stop();
    int hi, n;
    logic [3:0] nv [2] = '{4'd0, 4'd12};
    logic [3:0] ov [2] = '{4'd9, 4'd10};
    for (int k = 0; k < 2; k++) begin
      note = 4'd12; octave = 4'd9;
      wait_rise("rest_rise");
      tick(500);
      note = nv[k]; octave = ov[k];
      measure_level(1'b1, hi);
      checks++;
      if (hi + 500 !== 3164 || active !== 1'b0) begin
        errors++;
        $display("FAIL rest_stop[%0d]: high=%0d active=%b want 3164 0", k, hi + 500, active);
      end
      n = 0;
      for (int i = 0; i < 7000; i++) begin
        if (audio !== 1'b0 || active !== 1'b0) n++;
        tick(1);
      end
      checks++;
      if (n !== 0) begin
        errors++;
        $display("FAIL rest_quiet[%0d]: nonzero samples=%0d want 0", k, n);
      end
    end
    // Invalid note arriving during a low phase: low completes, then active drops.
    note = 4'd12; octave = 4'd9;
    wait_rise("low_rise");
    measure_level(1'b1, hi);
    tick(200);
    note = 4'd14;
    n = 200;
    while (active === 1'b1 && n < 20000) begin
      n++;
      tick(1);
    end
    checks++;
    if (n !== 3164 || audio !== 1'b0) begin
      errors++;
      $display("FAIL rest_low: low=%0d audio=%b want 3164 0", n, audio);
    end
    do_reset();
  endtask

  task automatic test_reset_mid_play();
    note = 4'd12; octave = 4'd9;
    wait_rise("rst_rise");
    tick(100);
    rst = 1'b1;
    tick(1);
    checks++;
    if (audio !== 1'b0 || active !== 1'b0 || half_period !== 22'd0) begin
      errors++;
      $display("FAIL rst_mid: audio=%b active=%b hp=%0d want 0 0 0", audio, active, half_period);
    end
    rst = 1'b0;
    tick(2);
    checks++;
    if (audio !== 1'b0) begin
      errors++;
      $display("FAIL rst_restart_c2: audio=%b want 0", audio);
    end
    tick(1);
    checks++;
    if (audio !== 1'b1 || active !== 1'b1) begin
      errors++;
      $display("FAIL rst_restart_c3: audio=%b active=%b want 1 1", audio, active);
    end
    do_reset();
  endtask

  task automatic test_pulse();
    int hi, n;
    note = 4'd10; octave = 4'd9;
    tick(1);
    note = 4'd0;
    wait_rise("pulse_rise");
    measure_level(1'b1, hi);
    checks++;
    if (hi !== 3551 || active !== 1'b0) begin
      errors++;
      $display("FAIL pulse_high: len=%0d active=%b want 3551 0", hi, active);
    end
    n = 0;
    for (int i = 0; i < 4000; i++) begin
      if (audio !== 1'b0 || active !== 1'b0) n++;
      tick(1);
    end
    checks++;
    if (n !== 0) begin
      errors++;
      $display("FAIL pulse_idle: nonzero samples=%0d want 0", n);
    end
  endtask

  initial begin
    rst = 1'b1; note = 4'd0; octave = 4'd0;
    test_reset();
    test_lut_values();
    test_start_and_period();
    test_mid_change();
    test_rest_stop();
    test_reset_mid_play();
    test_pulse();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
